// File: rtl/cv32e40s_instr_obi_queue_if.sv
// ============================================================================
// Module  : cv32e40s_instr_obi_queue_if
// Brief   : Instruction-fetch OBI master adapter with a request queue, bounded
//           outstanding transactions, flush/discard and gnt/rvalid parity
//           checking (enabled by CV32E40S_OBI_PARITY_CHECK_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40s_instr_obi_queue_if #(
    parameter int ADDR_W          = 32,
    parameter int REQ_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trans_valid_i,
    output logic              trans_ready_o,
    input  logic [ADDR_W-1:0] trans_addr_i,
    input  logic [2:0]        trans_prot_i,
    input  logic              flush_i,
    output logic              obi_req_o,
    output logic              obi_reqpar_o,
    input  logic              obi_gnt_i,
    input  logic              obi_gntpar_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic [2:0]        obi_prot_o,
    input  logic              obi_rvalid_i,
    input  logic              obi_rvalidpar_i,
    input  logic [31:0]       obi_rdata_i,
    input  logic              obi_err_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              resp_integrity_err_o,
    output logic              integrity_err_o,
    output logic [CNT_W-1:0]  outstnd_cnt_o
);

    localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int OCC_W = $clog2(REQ_DEPTH + 1);

    logic [ADDR_W-3:0] q_addr [REQ_DEPTH];
    logic [2:0]        q_prot [REQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  cnt, cnt_next, discard_q, discard_next;
    logic              head_presented_q, head_stale_q, gnt_err_q, integrity_err_q;
    logic              push, pop, keep_head, rvalid_ok, proto_viol, drop_resp;
    logic              gnt_err, rvalid_err;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^trans_addr_i[1:0];

    assign rd_ptr_inc = (rd_ptr == PTR_W'(REQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_inc = (wr_ptr == PTR_W'(REQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    assign trans_ready_o = (occ < OCC_W'(REQ_DEPTH)) && !flush_i && !rst;
    assign push          = trans_valid_i && trans_ready_o;

    // Once presented, the head keeps req high even when the outstanding cap is reached
    assign obi_req_o    = (occ != '0) && ((cnt < CNT_W'(MAX_OUTSTANDING)) || head_presented_q);
    assign obi_reqpar_o = ~obi_req_o;
    assign obi_addr_o   = {q_addr[rd_ptr], 2'b00};
    assign obi_prot_o   = q_prot[rd_ptr];
    assign pop          = obi_req_o && obi_gnt_i;
    assign keep_head    = obi_req_o && !obi_gnt_i;

    assign proto_viol   = obi_rvalid_i && (cnt == '0);
    assign rvalid_ok    = obi_rvalid_i && (cnt != '0);
    assign cnt_next     = cnt + CNT_W'(pop) - CNT_W'(rvalid_ok);
    assign drop_resp    = rvalid_ok && (discard_q != '0);
    assign discard_next = discard_q - CNT_W'(drop_resp) + CNT_W'(pop && head_stale_q);

    assign resp_valid_o    = rvalid_ok && !drop_resp;
    assign resp_rdata_o    = obi_rdata_i;
    assign resp_err_o      = obi_err_i;
    assign integrity_err_o = integrity_err_q;
    assign outstnd_cnt_o   = cnt;

`ifdef CV32E40S_OBI_PARITY_CHECK_EN
    assign gnt_err              = (obi_gnt_i == obi_gntpar_i);
    assign rvalid_err           = (obi_rvalid_i == obi_rvalidpar_i);
    assign resp_integrity_err_o = rvalid_err || gnt_err_q;
`else
    logic unused_parity;
    assign unused_parity        = obi_gntpar_i ^ obi_rvalidpar_i;
    assign gnt_err              = 1'b0;
    assign rvalid_err           = 1'b0;
    assign resp_integrity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= trans_addr_i[ADDR_W-1:2];
            q_prot[wr_ptr] <= trans_prot_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            occ              <= '0;
            cnt              <= '0;
            discard_q        <= '0;
            head_presented_q <= 1'b0;
            head_stale_q     <= 1'b0;
            gnt_err_q        <= 1'b0;
            integrity_err_q  <= 1'b0;
        end else begin
            cnt              <= cnt_next;
            head_presented_q <= keep_head;
            gnt_err_q        <= gnt_err || (gnt_err_q && !obi_rvalid_i);
            integrity_err_q  <= integrity_err_q || gnt_err || rvalid_err || proto_viol;
            if (flush_i) begin
                // Every transaction still owed a response after this edge is discarded
                discard_q <= cnt_next;
                if (keep_head) begin
                    occ          <= OCC_W'(1);
                    wr_ptr       <= rd_ptr_inc;
                    head_stale_q <= 1'b1;
                end else begin
                    occ          <= '0;
                    rd_ptr       <= '0;
                    wr_ptr       <= '0;
                    head_stale_q <= 1'b0;
                end
            end else begin
                discard_q <= discard_next;
                occ       <= occ + OCC_W'(push) - OCC_W'(pop);
                if (pop) begin
                    rd_ptr       <= rd_ptr_inc;
                    head_stale_q <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr_inc;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/cv32e40s_instr_obi_queue_if.md
# cv32e40s_instr_obi_queue_if

Parametrised OBI instruction-fetch master adapter with bounded outstanding transactions. It sits between the prefetcher and the instruction OBI port. It buffers up to REQ_DEPTH fetch requests in a queue and drives the OBI A channel from the queue head, so the address phase stays stable without retraction. It caps in-flight transactions at MAX_OUTSTANDING and supports a flush that drops queued requests and discards responses still owed for already-issued fetches. It also performs gnt/rvalid parity checking with a sticky integrity error.

## Interface
Parameters:
- ADDR_W, 32, fetch address width.
- REQ_DEPTH, 2, request queue entries (≥1; need not be a power of two).
- MAX_OUTSTANDING, 2, granted-but-unanswered limit (≥1); CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- trans_valid_i  in  1  fetch request valid.
- trans_ready_o  out  1  queue can accept a request.
- trans_addr_i  in  ADDR_W  word-aligned fetch address; bits [1:0] are ignored and driven 0.
- trans_prot_i  in  3  protection attributes.
- flush_i  in  1  discard queued requests and pending responses.
- obi_req_o / obi_reqpar_o  out  1 / 1  OBI request; reqpar = ~req.
- obi_gnt_i / obi_gntpar_i  in  1 / 1  grant and its inverted parity.
- obi_addr_o  out  ADDR_W  address-phase address.
- obi_prot_o  out  3  address-phase prot.
- obi_rvalid_i / obi_rvalidpar_i  in  1 / 1  response valid and its inverted parity.
- obi_rdata_i  in  32  read data.
- obi_err_i  in  1  bus error.
- resp_valid_o  out  1  response to the consumer, which is always ready.
- resp_rdata_o  out  32  passthrough of obi_rdata_i.
- resp_err_o  out  1  passthrough of obi_err_i.
- resp_integrity_err_o  out  1  parity error attached to this response.
- integrity_err_o  out  1  sticky integrity alert.
- outstnd_cnt_o  out  CNT_W  current outstanding count.

## Operation
Request queue:
- Circular FIFO; wr/rd pointers wrap at REQ_DEPTH−1→0; occupancy counter 0..REQ_DEPTH.
- trans_ready_o = (occ < REQ_DEPTH) && !flush_i && !rst.
- Push on trans_valid_i && trans_ready_o.

OBI A channel:
- obi_req_o = (occ ≠ 0) && (cnt < MAX_OUTSTANDING || head_presented_q).
- obi_addr_o / obi_prot_o are driven from the head entry.
- head_presented_q is set when req=1 && gnt=0, and cleared on grant.
- While head_presented_q is set, req stays 1 and the head stays fixed, flush included: a presented request is never retracted.
- Pop the head on req && gnt.

Outstanding counter:
- +1 on req && gnt, −1 on rvalid; both in one cycle leaves it unchanged.
- Saturates in neither direction; the cap is enforced by the req gating above.

Flush:
- All non-presented entries are dropped.
- If the head is presented, only the head is kept and marked stale.
- discard_q ← cnt_next (includes a grant in the flush cycle).
- A stale head that is later granted increments discard_q.

Responses:
- On rvalid with discard_q > 0: decrement discard_q; resp_valid_o = 0.
- Otherwise resp_valid_o = obi_rvalid_i.

Integrity:
- gnt error = (gnt == gntpar); rvalid error = (rvalid == rvalidpar).
- resp_integrity_err_o = rvalid error || a gnt error latched since the last response.
- rvalid while cnt == 0 is a protocol violation: integrity_err_o is set and the response is dropped.
- integrity_err_o is sticky until rst.

## Timing
- Reset values: obi_req_o 0, obi_reqpar_o 1, resp_valid_o 0, integrity_err_o 0, outstnd_cnt_o 0, trans_ready_o 0 during rst and 1 the cycle after. Queue empty, discard_q 0.
- Request on trans_* with an empty queue: obi_req_o asserts the following cycle (registered queue, 1-cycle latency).
- Response path is combinational: rvalid → resp_valid_o in the same cycle.
- Full queue: push is blocked. A push and pop in the same cycle at full are not allowed, because ready is already low.
- Reset mid-transaction clears all state regardless of outstanding bus traffic.

## Configuration
- CV32E40S_OBI_PARITY_CHECK_EN defined: gntpar/rvalidpar are checked as above.
- Undefined: parity inputs are ignored, resp_integrity_err_o is tied 0, and integrity_err_o is set only by the rvalid-while-cnt==0 violation.
- obi_reqpar_o is always driven in both builds.

## Test plan
- Back-to-back fetches 0x100, 0x104, 0x108 with MAX_OUTSTANDING=2 and no rvalid → two grants, then obi_req_o=0 with outstnd_cnt_o=2. First rvalid → third request issues next cycle.
- Grant withheld 3 cycles on 0x200 while trans_addr_i changes → obi_addr_o stays 0x200 and obi_req_o stays 1 until gnt.
- Flush with 2 outstanding, 1 presented-ungranted, 1 queued → queued entry dropped, head held until gnt. The next 3 rvalids give resp_valid_o=0; the 4th response (new fetch) gives resp_valid_o=1.
- Grant and rvalid in the same cycle at cnt=1 → cnt stays 1, head popped, response delivered.
- gntpar==gnt for one cycle (macro defined) → integrity_err_o=1 next cycle and stays 1; next response has resp_integrity_err_o=1. With the macro undefined → both 0.
- rvalid while cnt==0 → resp_valid_o=0, integrity_err_o=1. Then rst=1 for one cycle → all outputs return to their reset values.
